// File: rtl/dds_pkg.sv
// Shared constants, FSM encoding and helpers for the multi-channel DDS phase accumulator.
package dds_pkg;

  localparam logic SEL_FTW = 1'b0;
  localparam logic SEL_POW = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DIRTY = 1'b1
  } state_t;

  // Fibonacci right-shift LFSR, x^16+x^14+x^13+x^11+1 -> feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dds_acc_channel.sv
// One DDS channel: shadow/active FTW+POW, phase accumulator, wrap pulse and ROM address register.
// DDS_PHASE_DITHER_EN adds a per-channel dither word below the address LSB before truncation.
module dds_acc_channel
  import dds_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 11,
  parameter int BY_W   = 2,
`ifdef DDS_PHASE_DITHER_EN
  parameter int DITH_W = 16,
`endif
  parameter logic [ACC_W-1:0] FTW_RST = {{(ACC_W-1){1'b0}}, 1'b1}
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              i_we,
  input  logic              i_sel,
  input  logic [BY_W-1:0]   i_byte,
  input  logic [7:0]        idata,
  input  logic              iupdate,
  input  logic              iphase_clr,
  input  logic              ien,
`ifdef DDS_PHASE_DITHER_EN
  input  logic [DITH_W-1:0] i_dither,
`endif
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wrap
);

  localparam int NBYTES = ACC_W / 8;

  logic [ACC_W-1:0]  r_ftw_sh;
  logic [ACC_W-1:0]  r_pow_sh;
  logic [ACC_W-1:0]  r_ftw_act;
  logic [ACC_W-1:0]  r_pow_act;
  logic [ACC_W-1:0]  r_acc;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wrap;
  logic [ACC_W:0]    w_sum;
  logic [ADDR_W-1:0] w_addr_next;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_ftw_act};

`ifdef DDS_PHASE_DITHER_EN
  assign w_addr_next = ADDR_W'((r_acc + r_pow_act + {{(ACC_W-DITH_W){1'b0}}, i_dither})
                               >> (ACC_W - ADDR_W));
`else
  assign w_addr_next = ADDR_W'((r_acc + r_pow_act) >> (ACC_W - ADDR_W));
`endif

  // Nonblocking copy means a same-cycle write lands in the shadow after the active copy.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_ftw_sh  <= FTW_RST;
      r_pow_sh  <= '0;
      r_ftw_act <= FTW_RST;
      r_pow_act <= '0;
    end else begin
      if (iupdate) begin
        r_ftw_act <= r_ftw_sh;
        r_pow_act <= r_pow_sh;
      end
      for (int b = 0; b < NBYTES; b++) begin
        if (i_we && (i_byte == BY_W'(b))) begin
          if (i_sel == SEL_FTW) r_ftw_sh[b*8 +: 8] <= idata;
          else                  r_pow_sh[b*8 +: 8] <= idata;
        end
      end
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
      r_addr <= '0;
    end else begin
      r_addr <= w_addr_next;
      if (iphase_clr) begin
        r_acc  <= '0;
        r_wrap <= 1'b0;
      end else if (ien) begin
        r_acc  <= w_sum[ACC_W-1:0];
        r_wrap <= w_sum[ACC_W];
      end else begin
        r_wrap <= 1'b0;
      end
    end
  end

  assign o_addr = r_addr;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/dds_phase_acc_mc.sv
// Multi-channel DDS phase accumulator: byte-serial shadow writes, global coherent update, per-channel ROM address.
// Optional DDS_PHASE_DITHER_EN: 16-bit LFSR dither added below the address LSB before truncation.
module dds_phase_acc_mc
  import dds_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 11,
  parameter logic [ACC_W-1:0] FTW_RST = {{(ACC_W-1){1'b0}}, 1'b1},
  localparam int CH_W  = clog2_min1(CH_NUM),
  localparam int BY_W  = clog2_min1(ACC_W / 8)
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     iwr,
  input  logic [CH_W+BY_W:0]       iaddr,
  input  logic [7:0]               idata,
  input  logic                     iupdate,
  input  logic                     iphase_clr,
  input  logic                     ien,
  output logic [CH_NUM*ADDR_W-1:0] oaddr,
  output logic [CH_NUM-1:0]        owrap,
  output logic                     opending
);

  localparam int NBYTES = ACC_W / 8;

  logic [CH_W-1:0] w_ch;
  logic            w_sel;
  logic [BY_W-1:0] w_byte;
  logic            w_wr_ok;
  state_t          r_state;
  state_t          w_state_next;

  assign w_ch    = iaddr[BY_W+1 +: CH_W];
  assign w_sel   = iaddr[BY_W];
  assign w_byte  = iaddr[BY_W-1:0];
  assign w_wr_ok = iwr && (32'(w_ch) < 32'(CH_NUM)) && (32'(w_byte) < 32'(NBYTES));

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // A write always wins over a same-cycle update, so the pending flag stays set.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_wr_ok) w_state_next = ST_DIRTY;
      ST_DIRTY: if (!w_wr_ok && iupdate) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign opending = (r_state == ST_DIRTY);

`ifdef DDS_PHASE_DITHER_EN
  localparam int DITH_W = ((ACC_W - ADDR_W) < 16) ? (ACC_W - ADDR_W) : 16;

  logic [15:0] r_lfsr;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) r_lfsr <= LFSR_SEED;
    else      r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic w_we;
      assign w_we = w_wr_ok && (w_ch == CH_W'(gi));

      dds_acc_channel #(
        .ACC_W   (ACC_W),
        .ADDR_W  (ADDR_W),
        .BY_W    (BY_W),
`ifdef DDS_PHASE_DITHER_EN
        .DITH_W  (DITH_W),
`endif
        .FTW_RST (FTW_RST)
      ) u_ch (
        .iclk       (iclk),
        .irst       (irst),
        .i_we       (w_we),
        .i_sel      (w_sel),
        .i_byte     (w_byte),
        .idata      (idata),
        .iupdate    (iupdate),
        .iphase_clr (iphase_clr),
        .ien        (ien),
`ifdef DDS_PHASE_DITHER_EN
        .i_dither   (DITH_W'((r_lfsr << (gi % 16)) | (r_lfsr >> ((16 - (gi % 16)) % 16)))),
`endif
        .o_addr     (oaddr[gi*ADDR_W +: ADDR_W]),
        .o_wrap     (owrap[gi])
      );
    end
  endgenerate

endmodule
